// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, width helpers and index type for regfile_sb.
// No ports; imported by reg_scoreboard and regfile_sb.
package regfile_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;
    localparam int NREAD_D = 2;

    // Address width for an n-entry file (at least 1 bit).
    function automatic int aw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value n itself.
    function automatic int cw_of(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int AW_D = aw_of(NREGS_D);
    localparam int CW_D = cw_of(NREGS_D);

    typedef logic [AW_D-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending bits with flush > issue > write-back
// priority. Ports: clk, rst_n, issue_*, wb_*, flush in; pending, busy_count, any_busy out.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_D,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = aw_of(NREGS),
    localparam int CW      = cw_of(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_addr,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    input  logic             flush,
    output logic [NREGS-1:0] pending,
    output logic [CW-1:0]    busy_count,
    output logic             any_busy
);

    logic [NREGS-1:0] pend_d;
    logic [CW-1:0]    cnt_d;

    // Later assignments win: wb clear, then issue set, then flush clear.
    // Out-of-range addresses never match an index below NREGS.
    always_comb begin
        pend_d = pending;
        for (int r = 0; r < NREGS; r++) begin
            if (wb_valid && wb_addr == AW'(r))
                pend_d[r] = 1'b0;
            if (issue_valid && issue_addr == AW'(r))
                pend_d[r] = 1'b1;
        end
        if (ZERO_REG)
            pend_d[0] = 1'b0;
        if (flush)
            pend_d = '0;
    end

    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++)
            cnt_d = cnt_d + CW'(pend_d[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            busy_count <= '0;
            any_busy   <= 1'b0;
        end else begin
            pending    <= pend_d;
            busy_count <= cnt_d;
            any_busy   <= |pend_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with NREAD combinational read ports, one write-back
// port, optional bypass and zero register, plus RAW scoreboard. Ports: clk, rst_n,
// rd_addr/rd_data/rd_busy, issue_*, wb_*, flush, busy_count, any_busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int NREGS    = NREGS_D,
    parameter int NREAD    = NREAD_D,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = aw_of(NREGS),
    localparam int CW      = cw_of(NREGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREAD-1:0][AW-1:0]   rd_addr,
    output logic [NREAD-1:0][XLEN-1:0] rd_data,
    output logic [NREAD-1:0]           rd_busy,
    input  logic                       issue_valid,
    input  logic [AW-1:0]              issue_addr,
    input  logic                       wb_valid,
    input  logic [AW-1:0]              wb_addr,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       flush,
    output logic [CW-1:0]              busy_count,
    output logic                       any_busy
);

    localparam logic [AW:0] NR = (AW + 1)'(NREGS);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pending;
    logic             wr_en;

    function automatic logic in_rng(input logic [AW-1:0] a);
        return {1'b0, a} < NR;
    endfunction

    function automatic logic live(input logic [AW-1:0] a);
        return in_rng(a) && !(ZERO_REG && a == '0);
    endfunction

    reg_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .flush       (flush),
        .pending     (pending),
        .busy_count  (busy_count),
        .any_busy    (any_busy)
    );

    assign wr_en = wb_valid && live(wb_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                mem[r] <= '0;
        end else if (wr_en) begin
            mem[wb_addr] <= wb_data;
        end
    end

    // Bypassed data is never busy: its producer is completing this cycle.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_data[i] = '0;
            rd_busy[i] = 1'b0;
            if (live(rd_addr[i])) begin
                if (BYPASS && wb_valid && wb_addr == rd_addr[i]) begin
                    rd_data[i] = wb_data;
                end else begin
                    rd_data[i] = mem[rd_addr[i]];
                    rd_busy[i] = pending[rd_addr[i]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives a bypass/32-entry and a no-bypass/24-entry register file
// with shared directed and random stimulus, checking both against an array model.
module tb_regfile_sb;

    logic clk;
    logic rst_n;
    logic iv;
    logic [4:0] ia;
    logic wv;
    logic [4:0] wa;
    logic [31:0] wd;
    logic fl;

    logic [1:0][4:0]  ra_a;
    logic [1:0][31:0] rd_a;
    logic [1:0]       rb_a;
    logic [5:0]       bc_a;
    logic             ab_a;

    logic [2:0][4:0]  ra_b;
    logic [2:0][31:0] rd_b;
    logic [2:0]       rb_b;
    logic [4:0]       bc_b;
    logic             ab_b;

    int tests = 0;
    int fails = 0;

    // Model: index 0 = 32 regs with bypass, index 1 = 24 regs without.
    int          m_nr [2] = '{32, 24};
    bit          m_byp[2] = '{1'b1, 1'b0};
    logic [31:0] m_mem[2][32];
    bit          m_pnd[2][32];

    regfile_sb #(
        .XLEN(32), .NREGS(32), .NREAD(2),
        .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(ra_a), .rd_data(rd_a), .rd_busy(rb_a),
        .issue_valid(iv), .issue_addr(ia),
        .wb_valid(wv), .wb_addr(wa), .wb_data(wd),
        .flush(fl), .busy_count(bc_a), .any_busy(ab_a)
    );

    regfile_sb #(
        .XLEN(32), .NREGS(24), .NREAD(3),
        .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(ra_b), .rd_data(rd_b), .rd_busy(rb_b),
        .issue_valid(iv), .issue_addr(ia),
        .wb_valid(wv), .wb_addr(wa), .wb_data(wd),
        .flush(fl), .busy_count(bc_b), .any_busy(ab_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Architectural update rules applied in order; last write wins, so
    // flush beats issue beats write-back for the pending bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++)
                for (int r = 0; r < 32; r++) begin
                    m_mem[d][r] <= '0;
                    m_pnd[d][r] <= 1'b0;
                end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (wv && int'(wa) < m_nr[d] && wa != 0) begin
                    m_mem[d][wa] <= wd;
                    m_pnd[d][wa] <= 1'b0;
                end
                if (iv && int'(ia) < m_nr[d] && ia != 0)
                    m_pnd[d][ia] <= 1'b1;
                if (fl)
                    for (int r = 0; r < 32; r++)
                        m_pnd[d][r] <= 1'b0;
            end
        end
    end

    task automatic exp_rd(input int d, input logic [4:0] a,
                          output logic [31:0] data, output logic busy);
        data = '0;
        busy = 1'b0;
        if (int'(a) < m_nr[d] && a != 0) begin
            if (m_byp[d] && wv && wa == a) begin
                data = wd;
            end else begin
                data = m_mem[d][a];
                busy = m_pnd[d][a];
            end
        end
    endtask

    function automatic int pcount(input int d);
        int n = 0;
        for (int r = 0; r < 32; r++)
            n += int'(m_pnd[d][r]);
        return n;
    endfunction

    always @(negedge clk) begin
        logic [31:0] ed;
        logic        eb;
        for (int i = 0; i < 2; i++) begin
            exp_rd(0, ra_a[i], ed, eb);
            check("a_rd_data", rd_a[i], ed);
            check("a_rd_busy", 32'(rb_a[i]), 32'(eb));
        end
        for (int i = 0; i < 3; i++) begin
            exp_rd(1, ra_b[i], ed, eb);
            check("b_rd_data", rd_b[i], ed);
            check("b_rd_busy", 32'(rb_b[i]), 32'(eb));
        end
        check("a_busy_count", 32'(bc_a), 32'(pcount(0)));
        check("a_any_busy", 32'(ab_a), 32'(pcount(0) != 0));
        check("b_busy_count", 32'(bc_b), 32'(pcount(1)));
        check("b_any_busy", 32'(ab_b), 32'(pcount(1) != 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iv = 1'b0; ia = '0;
        wv = 1'b0; wa = '0; wd = '0;
        fl = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        ra_a = '0;
        ra_b = '0;
        repeat (2) tick();
        rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            ra_a[0] = 5'(a);  ra_a[1] = 5'(31 - a);
            ra_b[0] = 5'(a);  ra_b[1] = 5'(31 - a);
            ra_b[2] = 5'(a ^ 7);
            #2;
            check("rst_rd0", rd_a[0], 32'h0);
            tick();
        end
        check("rst_count", 32'(bc_a), 32'h0);

        iv = 1'b1; ia = 5'd5;
        tick();
        idle();
        ra_a[0] = 5'd5;
        #2;
        check("iss5_busy", 32'(rb_a[0]), 32'h1);
        check("iss5_count", 32'(bc_a), 32'h1);
        tick();
        wv = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        #2;
        check("byp5_data", rd_a[0], 32'hDEADBEEF);
        check("byp5_busy", 32'(rb_a[0]), 32'h0);
        tick();
        idle();
        #2;
        check("wb5_count", 32'(bc_a), 32'h0);
        check("wb5_data", rd_a[0], 32'hDEADBEEF);

        iv = 1'b1; ia = 5'd7;
        tick();
        wv = 1'b1; wa = 5'd7; wd = 32'h12;
        tick();
        idle();
        ra_a[0] = 5'd7;
        #2;
        check("iw7_data", rd_a[0], 32'h12);
        check("iw7_busy", 32'(rb_a[0]), 32'h1);
        check("iw7_count", 32'(bc_a), 32'h1);

        fl = 1'b1;
        tick();
        iv = 1'b1; ia = 5'd0;
        wv = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        ra_a[0] = 5'd0;
        #2;
        check("r0_data", rd_a[0], 32'h0);
        check("r0_busy", 32'(rb_a[0]), 32'h0);
        tick();
        idle();
        #2;
        check("r0_count", 32'(bc_a), 32'h0);

        iv = 1'b1;
        ia = 5'd3; tick();
        ia = 5'd4; tick();
        ia = 5'd9; tick();
        idle();
        #2;
        check("iss3_count", 32'(bc_a), 32'h3);
        fl = 1'b1; iv = 1'b1; ia = 5'd10;
        tick();
        idle();
        ra_a[0] = 5'd10;
        #2;
        check("fl_count", 32'(bc_a), 32'h0);
        check("fl_any", 32'(ab_a), 32'h0);
        check("fl_r10", 32'(rb_a[0]), 32'h0);

        iv = 1'b1; ia = 5'd2;
        tick();
        idle();
        wv = 1'b1; wa = 5'd2; wd = 32'h55;
        ra_b[0] = 5'd2; ra_b[1] = 5'd30;
        #2;
        check("nb_old", rd_b[0], 32'h0);
        check("nb_busy", 32'(rb_b[0]), 32'h1);
        check("oor_data", rd_b[1], 32'h0);
        check("oor_busy", 32'(rb_b[1]), 32'h0);
        tick();
        idle();
        #2;
        check("nb_new", rd_b[0], 32'h55);
        check("nb_clr", 32'(rb_b[0]), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            iv = ($urandom_range(0, 1) == 1);
            ia = 5'($urandom_range(0, 31));
            wv = ($urandom_range(0, 1) == 1);
            wa = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 31));
            wd = $urandom;
            fl = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < 2; i++)
                ra_a[i] = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            for (int i = 0; i < 3; i++)
                ra_b[i] = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            tick();
        end

        idle();
        wv = 1'b1; wa = 5'd6; wd = 32'hABCD;
        iv = 1'b1; ia = 5'd8;
        tick();
        idle();
        ra_a[0] = 5'd6; ra_b[0] = 5'd6;
        ra_a[1] = 5'd8; ra_b[1] = 5'd8;
        #2;
        check("pre_rst_a", rd_a[0], 32'hABCD);
        check("pre_rst_b", rd_b[0], 32'hABCD);
        check("pre_rst_bsy", 32'(rb_a[1]), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_a_data", rd_a[0], 32'h0);
        check("arst_b_data", rd_b[0], 32'h0);
        check("arst_a_busy", 32'(rb_a[1]), 32'h0);
        check("arst_a_count", 32'(bc_a), 32'h0);
        check("arst_a_any", 32'(ab_a), 32'h0);
        check("arst_b_count", 32'(bc_b), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
